// File: rtl/hart_debug_ctl_if.sv
// Debug-module / hart-control bundle for hart_debug_ctl; all vectors carry one bit (or field) per hart.
// Per-hart fields: pc_reg/pc_next/dpc_out use [i*XLEN +: XLEN], cause_out uses [i*3 +: 3].
interface hart_debug_ctl_if #(
    parameter int NHARTS = 2,
    parameter int XLEN   = 32
);
    logic [NHARTS-1:0]      halt_req;
    logic [NHARTS-1:0]      resume_req;
    logic [NHARTS-1:0]      ackhavereset;
    logic [NHARTS-1:0]      resethaltreq;
    logic [NHARTS-1:0]      instr_end;
    logic [NHARTS-1:0]      ebreak;
    logic [NHARTS-1:0]      trigger_hit;
    logic [NHARTS-1:0]      step_en;
    logic [NHARTS-1:0]      core_halted;
    logic [NHARTS-1:0]      core_resumed;
    logic [NHARTS*XLEN-1:0] pc_reg;
    logic [NHARTS*XLEN-1:0] pc_next;

    logic [NHARTS-1:0]      debug_mode;
    logic [NHARTS-1:0]      halted;
    logic [NHARTS-1:0]      running;
    logic [NHARTS-1:0]      resume_ack;
    logic [NHARTS-1:0]      havereset;
    logic [NHARTS-1:0]      dpc_we;
    logic [NHARTS*XLEN-1:0] dpc_out;
    logic [NHARTS*3-1:0]    cause_out;

    modport master (
        output halt_req, resume_req, ackhavereset, resethaltreq, instr_end, ebreak,
               trigger_hit, step_en, core_halted, core_resumed, pc_reg, pc_next,
        input  debug_mode, halted, running, resume_ack, havereset, dpc_we, dpc_out, cause_out
    );

    modport slave (
        input  halt_req, resume_req, ackhavereset, resethaltreq, instr_end, ebreak,
               trigger_hit, step_en, core_halted, core_resumed, pc_reg, pc_next,
        output debug_mode, halted, running, resume_ack, havereset, dpc_we, dpc_out, cause_out
    );
endinterface

// File: rtl/hart_debug_ctl.sv
// Per-hart debug-mode controller: RUN -> HALTING -> HALTED -> RESUMING -> RUN for each of NHARTS harts.
// Optional halt-on-reset is enabled by defining HART_DEBUG_CTL_RESETHALT_EN.
module hart_debug_ctl #(
    parameter int NHARTS = 2,
    parameter int XLEN   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    hart_debug_ctl_if.slave dbg
);
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALTING   = 2'd1,
        ST_HALTED    = 2'd2,
        ST_RESUMING  = 2'd3
    } hart_state_e;

    localparam logic [2:0] CAUSE_EBREAK    = 3'd1;
    localparam logic [2:0] CAUSE_TRIGGER   = 3'd2;
    localparam logic [2:0] CAUSE_HALTREQ   = 3'd3;
    localparam logic [2:0] CAUSE_STEP      = 3'd4;
    localparam logic [2:0] CAUSE_RESETHALT = 3'd5;

`ifndef HART_DEBUG_CTL_RESETHALT_EN
    logic unused_resethaltreq;
    assign unused_resethaltreq = ^dbg.resethaltreq;
`endif

    generate
        for (genvar gi = 0; gi < NHARTS; gi++) begin : g_hart
            hart_state_e     state_q, state_d;
            logic            pending_q, pending_d;
            logic            havereset_q, havereset_d;
            logic            resume_ack_q, resume_ack_d;
            logic [2:0]      cause_q, cause_d;
            logic            resethalt_hit;
            logic            entry;
            logic [2:0]      entry_cause;
            logic [XLEN-1:0] entry_dpc;
            logic [XLEN-1:0] pc_reg_h;
            logic [XLEN-1:0] pc_next_h;

            assign pc_reg_h  = dbg.pc_reg[gi*XLEN +: XLEN];
            assign pc_next_h = dbg.pc_next[gi*XLEN +: XLEN];

`ifdef HART_DEBUG_CTL_RESETHALT_EN
            // Captured while reset is held, consumed on the first cycle after release.
            logic resethalt_q, resethalt_d;

            always_comb begin
                resethalt_d = 1'b0;
                if (!rst_n) begin
                    resethalt_d = dbg.resethaltreq[gi];
                end
            end

            always_ff @(posedge clk) begin
                resethalt_q <= resethalt_d;
            end

            assign resethalt_hit = resethalt_q;
`else
            assign resethalt_hit = 1'b0;
`endif

            // Entry decode in priority order; only meaningful while running.
            always_comb begin
                entry       = 1'b0;
                entry_cause = 3'd0;
                entry_dpc   = pc_reg_h;
                if (state_q == ST_RUN) begin
                    if (resethalt_hit) begin
                        entry       = 1'b1;
                        entry_cause = CAUSE_RESETHALT;
                    end else if (dbg.trigger_hit[gi]) begin
                        entry       = 1'b1;
                        entry_cause = CAUSE_TRIGGER;
                    end else if (dbg.ebreak[gi]) begin
                        entry       = 1'b1;
                        entry_cause = CAUSE_EBREAK;
                    end else if (dbg.halt_req[gi] || pending_q) begin
                        entry       = 1'b1;
                        entry_cause = CAUSE_HALTREQ;
                        entry_dpc   = dbg.instr_end[gi] ? pc_next_h : pc_reg_h;
                    end else if (dbg.step_en[gi] && dbg.instr_end[gi]) begin
                        entry       = 1'b1;
                        entry_cause = CAUSE_STEP;
                        entry_dpc   = pc_next_h;
                    end
                end
            end

            always_comb begin
                state_d      = state_q;
                pending_d    = pending_q;
                cause_d      = cause_q;
                resume_ack_d = 1'b0;
                havereset_d  = havereset_q & ~dbg.ackhavereset[gi];
                case (state_q)
                    ST_RUN: begin
                        if (entry) begin
                            state_d = ST_HALTING;
                            cause_d = entry_cause;
                        end
                    end
                    ST_HALTING: begin
                        if (dbg.core_halted[gi]) begin
                            state_d   = ST_HALTED;
                            pending_d = 1'b0;
                        end
                    end
                    ST_HALTED: begin
                        if (dbg.resume_req[gi]) begin
                            state_d = ST_RESUMING;
                        end
                    end
                    ST_RESUMING: begin
                        // A halt arriving now is remembered and honoured on the first RUN cycle.
                        if (dbg.halt_req[gi]) begin
                            pending_d = 1'b1;
                        end
                        if (dbg.core_resumed[gi]) begin
                            state_d      = ST_RUN;
                            resume_ack_d = 1'b1;
                        end
                    end
                    default: state_d = ST_RUN;
                endcase
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q      <= ST_RUN;
                    pending_q    <= 1'b0;
                    cause_q      <= 3'd0;
                    resume_ack_q <= 1'b0;
                    havereset_q  <= 1'b1;
                end else begin
                    state_q      <= state_d;
                    pending_q    <= pending_d;
                    cause_q      <= cause_d;
                    resume_ack_q <= resume_ack_d;
                    havereset_q  <= havereset_d;
                end
            end

            assign dbg.debug_mode[gi]              = (state_q != ST_RUN);
            assign dbg.halted[gi]                  = (state_q == ST_HALTED);
            assign dbg.running[gi]                 = (state_q == ST_RUN);
            assign dbg.resume_ack[gi]              = resume_ack_q;
            assign dbg.havereset[gi]               = havereset_q;
            assign dbg.dpc_we[gi]                  = entry & rst_n;
            assign dbg.dpc_out[gi*XLEN +: XLEN]    = entry_dpc;
            assign dbg.cause_out[gi*3 +: 3]        = cause_q;
        end
    endgenerate
endmodule

// File: tb/tb_hart_debug_ctl.sv
// Self-checking bench for hart_debug_ctl: directed debug scenarios followed by random traffic,
// every cycle compared against a behavioural per-hart model.
module tb_hart_debug_ctl;
    localparam int NH = 2;
    localparam int XL = 32;
    localparam int M_RUN = 0, M_HALTING = 1, M_HALTED = 2, M_RESUMING = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hart_debug_ctl_if #(.NHARTS(NH), .XLEN(XL)) bus ();
    hart_debug_ctl #(.NHARTS(NH), .XLEN(XL)) dut (.clk(clk), .rst_n(rst_n), .dbg(bus));

    int n_pass   = 0;
    int n_checks = 0;

    // Reference model state per hart
    int      m_state [NH];
    bit      m_pend  [NH];
    int      m_cause [NH];
    bit      m_hrst  [NH];
    bit      m_rack  [NH];
    bit      m_rsth  [NH];
    // Expected combinational entry for the current cycle
    bit          e_we    [NH];
    int          e_cause [NH];
    logic [XL-1:0] e_dpc [NH];
    // Outputs sampled at the last negedge
    logic [NH-1:0]    s_we, s_halted, s_running, s_dbg, s_rack, s_hrst;
    logic [NH*3-1:0]  s_cause;
    logic [NH*XL-1:0] s_dpc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic idle();
        bus.halt_req = '0; bus.resume_req = '0; bus.ackhavereset = '0; bus.resethaltreq = '0;
        bus.instr_end = '0; bus.ebreak = '0; bus.trigger_hit = '0; bus.step_en = '0;
        bus.core_halted = '0; bus.core_resumed = '0; bus.pc_reg = '0; bus.pc_next = '0;
    endtask

    task automatic set_pc(input int h, input logic [XL-1:0] cur, input logic [XL-1:0] nxt);
        bus.pc_reg[h*XL +: XL]  = cur;
        bus.pc_next[h*XL +: XL] = nxt;
    endtask

    task automatic model_eval();
        logic [XL-1:0] pcr, pcn;
        for (int h = 0; h < NH; h++) begin
            pcr = bus.pc_reg[h*XL +: XL];
            pcn = bus.pc_next[h*XL +: XL];
            e_we[h] = 1'b0; e_cause[h] = 0; e_dpc[h] = '0;
            if (rst_n && m_state[h] == M_RUN) begin
                if (m_rsth[h])                          begin e_we[h] = 1; e_cause[h] = 5; e_dpc[h] = pcr; end
                else if (bus.trigger_hit[h])            begin e_we[h] = 1; e_cause[h] = 2; e_dpc[h] = pcr; end
                else if (bus.ebreak[h])                 begin e_we[h] = 1; e_cause[h] = 1; e_dpc[h] = pcr; end
                else if (bus.halt_req[h] || m_pend[h])  begin e_we[h] = 1; e_cause[h] = 3;
                                                              e_dpc[h] = bus.instr_end[h] ? pcn : pcr; end
                else if (bus.step_en[h] && bus.instr_end[h]) begin e_we[h] = 1; e_cause[h] = 4; e_dpc[h] = pcn; end
            end
        end
    endtask

    task automatic model_step();
        for (int h = 0; h < NH; h++) begin
            if (!rst_n) begin
                m_state[h] = M_RUN; m_pend[h] = 0; m_cause[h] = 0; m_hrst[h] = 1; m_rack[h] = 0;
`ifdef HART_DEBUG_CTL_RESETHALT_EN
                m_rsth[h] = bus.resethaltreq[h];
`else
                m_rsth[h] = 0;
`endif
            end else begin
                m_rack[h] = 0;
                m_rsth[h] = 0;
                if (bus.ackhavereset[h]) m_hrst[h] = 0;
                case (m_state[h])
                    M_RUN:      if (e_we[h]) begin m_state[h] = M_HALTING; m_cause[h] = e_cause[h]; end
                    M_HALTING:  if (bus.core_halted[h]) begin m_state[h] = M_HALTED; m_pend[h] = 0; end
                    M_HALTED:   if (bus.resume_req[h]) m_state[h] = M_RESUMING;
                    default: begin
                        if (bus.halt_req[h]) m_pend[h] = 1;
                        if (bus.core_resumed[h]) begin m_state[h] = M_RUN; m_rack[h] = 1; end
                    end
                endcase
            end
        end
    endtask

    // One clock: compare at negedge, advance the model at posedge, return 1 time unit later.
    task automatic cycle();
        @(negedge clk);
        model_eval();
        s_we = bus.dpc_we; s_halted = bus.halted; s_running = bus.running; s_dbg = bus.debug_mode;
        s_rack = bus.resume_ack; s_hrst = bus.havereset; s_cause = bus.cause_out; s_dpc = bus.dpc_out;
        for (int h = 0; h < NH; h++) begin
            check($sformatf("h%0d_running", h),    64'(s_running[h]), 64'(m_state[h] == M_RUN));
            check($sformatf("h%0d_halted", h),     64'(s_halted[h]),  64'(m_state[h] == M_HALTED));
            check($sformatf("h%0d_debug_mode", h), 64'(s_dbg[h]),     64'(m_state[h] != M_RUN));
            check($sformatf("h%0d_resume_ack", h), 64'(s_rack[h]),    64'(m_rack[h]));
            check($sformatf("h%0d_havereset", h),  64'(s_hrst[h]),    64'(m_hrst[h]));
            check($sformatf("h%0d_cause_out", h),  64'(s_cause[h*3 +: 3]), 64'(m_cause[h]));
            check($sformatf("h%0d_dpc_we", h),     64'(s_we[h]),      64'(e_we[h]));
            if (e_we[h]) begin
                check($sformatf("h%0d_dpc_out", h), 64'(s_dpc[h*XL +: XL]), 64'(e_dpc[h]));
                $display("hart %0d debug entry cause %0d dpc %08h", h, e_cause[h], s_dpc[h*XL +: XL]);
            end
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        model_step();
        #1;
        cycle();
        check("rst_running", 64'(s_running), 64'(2'b11));
        check("rst_havereset", 64'(s_hrst), 64'(2'b11));
        rst_n = 1'b1;

        // Halt request on hart 0
        bus.halt_req = 2'b01; set_pc(0, 32'h100, 32'h104);
        cycle();
        check("tp_halt_we", 64'(s_we[0]), 64'd1);
        check("tp_halt_dpc", 64'(s_dpc[31:0]), 64'h100);
        check("tp_h1_run", 64'(s_running[1]), 64'd1);
        bus.halt_req = '0; bus.resume_req = 2'b01;
        cycle();
        check("tp_halt_cause", 64'(s_cause[2:0]), 64'd3);
        bus.resume_req = '0; bus.core_halted = 2'b01;
        cycle();
        check("tp_resume_ignored", 64'(s_halted[0]), 64'd0);
        check("tp_still_halting", 64'(s_dbg[0]), 64'd1);
        bus.core_halted = '0;
        cycle();
        check("tp_halted", 64'(s_halted[0]), 64'd1);
        check("tp_h1_running", 64'(s_running[1]), 64'd1);

        // Resume with single-step
        bus.step_en = 2'b01; bus.resume_req = 2'b01;
        cycle();
        bus.resume_req = '0; bus.core_resumed = 2'b01;
        cycle();
        check("tp_rack_early", 64'(s_rack[0]), 64'd0);
        bus.core_resumed = '0;
        cycle();
        check("tp_rack", 64'(s_rack[0]), 64'd1);
        bus.instr_end = 2'b01; set_pc(0, 32'h304, 32'h308);
        cycle();
        check("tp_rack_one_cycle", 64'(s_rack[0]), 64'd0);
        check("tp_step_we", 64'(s_we[0]), 64'd1);
        check("tp_step_dpc", 64'(s_dpc[31:0]), 64'h308);
        bus.instr_end = '0; bus.step_en = '0;
        cycle();
        check("tp_step_cause", 64'(s_cause[2:0]), 64'd4);

        // Halt request while resuming becomes pending
        bus.core_halted = 2'b01; cycle(); bus.core_halted = '0;
        bus.resume_req = 2'b01; cycle(); bus.resume_req = '0;
        bus.halt_req = 2'b01; cycle(); bus.halt_req = '0;
        bus.core_resumed = 2'b01; cycle(); bus.core_resumed = '0;
        set_pc(0, 32'h400, 32'h404);
        cycle();
        check("tp_pend_rack", 64'(s_rack[0]), 64'd1);
        check("tp_pend_we", 64'(s_we[0]), 64'd1);
        check("tp_pend_dpc", 64'(s_dpc[31:0]), 64'h400);
        cycle();
        check("tp_pend_dbg", 64'(s_dbg[0]), 64'd1);
        check("tp_pend_cause", 64'(s_cause[2:0]), 64'd3);

        // Trigger beats halt_req
        bus.core_halted = 2'b01; cycle(); bus.core_halted = '0;
        bus.resume_req = 2'b01; cycle(); bus.resume_req = '0;
        bus.core_resumed = 2'b01; cycle(); bus.core_resumed = '0;
        cycle();
        bus.trigger_hit = 2'b01; bus.halt_req = 2'b01; set_pc(0, 32'h200, 32'h204);
        cycle();
        check("tp_trig_dpc", 64'(s_dpc[31:0]), 64'h200);
        bus.trigger_hit = '0; bus.halt_req = '0;
        cycle();
        check("tp_trig_cause", 64'(s_cause[2:0]), 64'd2);

        // Reset while resuming, then acknowledge havereset on hart 0
        bus.core_halted = 2'b01; cycle(); bus.core_halted = '0;
        bus.resume_req = 2'b01; cycle(); bus.resume_req = '0;
        rst_n = 1'b0; bus.halt_req = 2'b01;
        cycle();
        check("tp_rst_no_we", 64'(s_we), 64'd0);
        rst_n = 1'b1; bus.halt_req = '0;
        cycle();
        check("tp_rst_running", 64'(s_running), 64'(2'b11));
        check("tp_rst_no_rack", 64'(s_rack), 64'd0);
        check("tp_rst_havereset", 64'(s_hrst), 64'(2'b11));
        bus.ackhavereset = 2'b01; cycle(); bus.ackhavereset = '0;
        cycle();
        check("tp_ack_havereset", 64'(s_hrst), 64'(2'b10));

        // Halt-on-reset request for hart 1 only
        rst_n = 1'b0; bus.resethaltreq = 2'b10; set_pc(1, 32'h500, 32'h504);
        cycle();
        rst_n = 1'b1; bus.resethaltreq = '0;
        cycle();
`ifdef HART_DEBUG_CTL_RESETHALT_EN
        check("tp_resethalt_we", 64'(s_we), 64'(2'b10));
        check("tp_resethalt_dpc", 64'(s_dpc[63:32]), 64'h500);
        cycle();
        check("tp_resethalt_cause", 64'(s_cause[5:3]), 64'd5);
`else
        check("tp_resethalt_off_we", 64'(s_we), 64'd0);
        cycle();
        check("tp_resethalt_off_run", 64'(s_running), 64'(2'b11));
`endif

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int h = 0; h < NH; h++) begin
                bus.halt_req[h]     = ($urandom_range(0, 9) == 0);
                bus.resume_req[h]   = ($urandom_range(0, 4) == 0);
                bus.ackhavereset[h] = ($urandom_range(0, 9) == 0);
                bus.resethaltreq[h] = ($urandom_range(0, 1) == 0);
                bus.instr_end[h]    = ($urandom_range(0, 4) < 2);
                bus.ebreak[h]       = ($urandom_range(0, 29) == 0);
                bus.trigger_hit[h]  = ($urandom_range(0, 29) == 0);
                bus.step_en[h]      = ($urandom_range(0, 2) == 0);
                bus.core_halted[h]  = ($urandom_range(0, 2) == 0);
                bus.core_resumed[h] = ($urandom_range(0, 2) == 0);
                set_pc(h, XL'($urandom) & ~32'h3, XL'($urandom) & ~32'h3);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hart_debug_ctl.md
Name: hart_debug_ctl

Overview:
- Per-hart debug-mode controller for an NHARTS-hart core cluster; generalises single-hart debug entry/exit to a vector of independent harts.
- Sits between the debug module (halt/resume request vectors) and each hart's control unit (instruction-end, ebreak, trigger, halted/resumed microstates).
- Each hart has an explicit 4-state FSM, prioritised cause capture, DPC capture, pending-halt tracking and havereset tracking.

Parameters:
- NHARTS, 2, number of independently controlled harts (>=1).
- XLEN, 32, PC/DPC width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- halt_req  in  NHARTS  DM halt request, level, per hart.
- resume_req  in  NHARTS  DM resume request, level, per hart.
- ackhavereset  in  NHARTS  clears havereset, per hart.
- resethaltreq  in  NHARTS  halt-on-reset request (see Optional Feature).
- instr_end  in  NHARTS  hart retires/redirects PC this cycle (write_pc or interrupt taken).
- ebreak  in  NHARTS  ebreak executed with dcsr.ebreakm set.
- trigger_hit  in  NHARTS  trigger match requesting debug entry.
- step_en  in  NHARTS  dcsr.step of each hart.
- core_halted  in  NHARTS  hart control has reached its halted microstate.
- core_resumed  in  NHARTS  hart control has left its resuming microstate.
- pc_reg  in  NHARTS*XLEN  current PC, hart i at [i*XLEN +: XLEN].
- pc_next  in  NHARTS*XLEN  next PC, same packing.
- debug_mode  out  NHARTS  hart in debug mode (HALTING/HALTED/RESUMING).
- halted  out  NHARTS  hart in HALTED.
- running  out  NHARTS  hart in RUN.
- resume_ack  out  NHARTS  1-cycle pulse on RESUMING->RUN.
- havereset  out  NHARTS  hart reset since last ackhavereset.
- dpc_we  out  NHARTS  1-cycle DPC/cause write strobe.
- dpc_out  out  NHARTS*XLEN  DPC write value, valid when dpc_we.
- cause_out  out  NHARTS*3  dcsr.cause of the last entry, registered.

Behaviour:
- Reset (synchronous): every FSM in RUN; running=all 1; debug_mode, halted, resume_ack, dpc_we = 0; cause_out=0; pending=0; havereset=all 1.
- FSM per hart: RUN(0) -> HALTING(1) -> HALTED(2) -> RESUMING(3) -> RUN.
- RUN: entry event = trigger_hit | ebreak | halt_req | pending | (step_en & instr_end). On the event, next state is HALTING, and the same cycle drives dpc_we=1 combinationally with dpc_out.
- Cause priority and DPC, cause registered into cause_out on the entry cycle:
  - trigger: cause 2, DPC = pc_reg.
  - ebreak: cause 1, DPC = pc_reg.
  - halt_req or pending: cause 3, DPC = instr_end ? pc_next : pc_reg.
  - step: cause 4, DPC = pc_next.
- HALTING: stay until core_halted, then HALTED next cycle.
- HALTED: halt_req is ignored; resume_req moves to RESUMING. pending is cleared on HALTED entry.
- RESUMING: stay until core_resumed, then RUN next cycle with resume_ack=1 for exactly that one cycle.
- In RESUMING, instr_end is not a step event.
- Outside HALTED, resume_req is ignored.
- A halt_req in RESUMING sets pending; the hart re-enters HALTING on the first RUN cycle, cause 3.
- Stepping: after resume with step_en=1, the first instr_end in RUN halts with cause 4. An interrupt taken counts as instr_end.
- Harts are fully independent; no cross-hart coupling.
- havereset clears the cycle after ackhavereset[i]=1; reset takes priority over ackhavereset.
- A reset in any state (mid-HALTING, mid-RESUMING) returns the hart to RUN with no resume_ack and no dpc_we.
- Outputs debug_mode, halted, running and resume_ack decode from registered state.

Optional Feature:
- Macro: HART_DEBUG_CTL_RESETHALT_EN.
- Defined: resethaltreq[i] is sampled during reset. The first post-reset cycle enters HALTING with cause 5 and DPC = pc_reg, with dpc_we=1 in that cycle.
- Not defined: resethaltreq is ignored; harts leave reset in RUN.

Test Plan:
- NHARTS=2. halt_req[0]=1 in RUN, instr_end=0, pc_reg=0x100 -> dpc_we[0]=1 with dpc_out=0x100 and cause 3. After core_halted, halted[0]=1. Hart 1 stays running=1.
- Trigger and halt_req in the same cycle, pc_reg=0x200, pc_next=0x204 -> cause 2, DPC 0x200.
- Resume with step_en=1 -> resume_ack 1 cycle after core_resumed. Next instr_end with pc_next=0x308 -> cause 4, DPC 0x308.
- halt_req pulsed while RESUMING -> resume_ack pulses, then HALTING on the next cycle with cause 3.
- resume_req while HALTING -> ignored, FSM stays HALTING. rst_n=0 mid-RESUMING -> RUN, havereset=1. ackhavereset -> 0 the next cycle.
- HART_DEBUG_CTL_RESETHALT_EN defined, resethaltreq[1]=1 -> after reset only hart 1 halts, cause 5.
